// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multicycle MIPS sequencer driving datapath enables and mux selects,
// with memory-ready handshake, wait watchdog, retire counter and sticky error state.
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           OP,
    input  logic [5:0]           Funct,
    input  logic                 Zero,
    input  logic                 MemReady,
    output logic                 PCWrite,
    output logic                 IRWrite,
    output logic                 IorD,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic [1:0]           RegDst,
    output logic [1:0]           MemtoReg,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [3:0]           ALUOp,
    output logic [1:0]           PCSource,
    output logic [CNT_WIDTH-1:0] RetiredCount,
    output logic                 Error
);
    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_I,
        WB_MEM, BRANCH, JUMP, JR, ERROR
    } state_t;
    state_t state, state_n;
    logic [7:0] wait_cnt;
    logic waiting, timeout;
    assign waiting = (state == FETCH || state == MEM_RD || state == MEM_WR) && !MemReady;
    assign timeout = waiting && wait_cnt == 8'(MEM_TIMEOUT - 1);
    assign Error   = state == ERROR;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= FETCH;
            wait_cnt     <= '0;
            RetiredCount <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= (waiting && !timeout) ? wait_cnt + 8'd1 : 8'd0;
            if (state_n == FETCH && state != FETCH)
                RetiredCount <= RetiredCount + CNT_WIDTH'(1);
        end
    end
    always_comb begin
        state_n  = state;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 2'd0;
        MemtoReg = 2'd0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'd0;
        ALUOp    = 4'b0000;
        PCSource = 2'd0;
        case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'd1;
                PCWrite = MemReady;
                IRWrite = MemReady;
                state_n = MemReady ? DECODE : timeout ? ERROR : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'd3;
                case (OP)
                    6'h00:                      state_n = (Funct == 6'h08) ? JR : EXEC_R;
                    6'h02, 6'h03:               state_n = JUMP;
                    6'h04, 6'h05:               state_n = BRANCH;
                    6'h08, 6'h0C, 6'h0D, 6'h0F: state_n = EXEC_I;
                    6'h23, 6'h2B:               state_n = MEM_ADDR;
                    default:                    state_n = ERROR;
                endcase
            end
            EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = 4'b0111;
                state_n = WB_R;
            end
            EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                // addi/andi/ori/lui map to 1000/1100/1101/1111: the low opcode bits carry over
                ALUOp   = {1'b1, OP[2:0]};
                state_n = WB_I;
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                state_n = (OP == 6'h23) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                state_n = MemReady ? WB_MEM : timeout ? ERROR : MEM_RD;
            end
            MEM_WR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                state_n  = MemReady ? FETCH : timeout ? ERROR : MEM_WR;
            end
            WB_R: begin
                RegDst   = 2'd1;
                RegWrite = 1'b1;
                state_n  = FETCH;
            end
            WB_I: begin
                RegWrite = 1'b1;
                state_n  = FETCH;
            end
            WB_MEM: begin
                MemtoReg = 2'd1;
                RegWrite = 1'b1;
                state_n  = FETCH;
            end
            BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 4'b0001;
                PCSource = 2'd1;
                PCWrite  = (OP == 6'h04) ? Zero : !Zero;
                state_n  = FETCH;
            end
            JUMP: begin
                PCSource = 2'd2;
                PCWrite  = 1'b1;
                RegDst   = (OP == 6'h03) ? 2'd2 : 2'd0;
                MemtoReg = (OP == 6'h03) ? 2'd2 : 2'd0;
                RegWrite = OP == 6'h03;
                state_n  = FETCH;
            end
            JR: begin
                PCSource = 2'd3;
                PCWrite  = 1'b1;
                state_n  = FETCH;
            end
            ERROR:   state_n = ERROR;
            default: state_n = ERROR;
        endcase
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end
endmodule
